// File: rtl/pfu_lut_pair_cfg_if.sv
// rtl/pfu_lut_pair_cfg_if.sv - bit-serial LUT configuration port (optional CFG_DOUT under PFU_LUT_READBACK_EN)
interface pfu_lut_pair_cfg_if;
    logic CFG_START;
    logic CFG_ABORT;
    logic CFG_DIN;
    logic CFG_VALID;
    logic CFG_READY;
    logic CFG_DONE;
`ifdef PFU_LUT_READBACK_EN
    logic CFG_DOUT;

    modport master (
        output CFG_START, CFG_ABORT, CFG_DIN, CFG_VALID,
        input  CFG_READY, CFG_DONE, CFG_DOUT
    );
    modport slave (
        input  CFG_START, CFG_ABORT, CFG_DIN, CFG_VALID,
        output CFG_READY, CFG_DONE, CFG_DOUT
    );
`else
    modport master (
        output CFG_START, CFG_ABORT, CFG_DIN, CFG_VALID,
        input  CFG_READY, CFG_DONE
    );
    modport slave (
        input  CFG_START, CFG_ABORT, CFG_DIN, CFG_VALID,
        output CFG_READY, CFG_DONE
    );
`endif
endinterface

// File: rtl/pfu_lut_pair_cfg.sv
// rtl/pfu_lut_pair_cfg.sv - dual K-input LUT with serial reload and atomic commit (readback: PFU_LUT_READBACK_EN)
module pfu_lut_pair_cfg #(
    parameter int                   LUT_K  = 4,
    parameter logic [2**LUT_K-1:0]  INIT_A = '0,
    parameter logic [2**LUT_K-1:0]  INIT_B = '0
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic [LUT_K-1:0]   LUT_IN,
    output logic               ALUT,
    output logic               BLUT,
    pfu_lut_pair_cfg_if.slave  cfg
);
    localparam int N = 2**LUT_K;
    localparam logic [LUT_K:0] LAST = (LUT_K+1)'(N-1);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, COMMIT} state_t;

    state_t             r_state;
    logic [LUT_K:0]     r_cnt;
    logic [N-1:0]       r_stg_a;
    logic [N-1:0]       r_stg_b;
    logic [N-1:0]       r_act_a;
    logic [N-1:0]       r_act_b;
    logic               r_alut;
    logic               r_blut;

    state_t             w_state_nxt;
    logic [LUT_K:0]     w_cnt_nxt;
    logic               w_ready;
    logic               w_done;
    logic               w_wr_a;
    logic               w_wr_b;
    logic               w_commit;
    logic [LUT_K-1:0]   w_idx;

    // cnt never exceeds N-1 while loading, so its low bits are the table index
    assign w_idx = r_cnt[LUT_K-1:0];

    // state and bit counter registers
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // next-state, handshake and write strobes; abort takes priority over a final transfer
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        w_wr_a      = 1'b0;
        w_wr_b      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg.CFG_START) begin
                    w_state_nxt = LOAD_A;
                    w_cnt_nxt   = '0;
                end
            end
            LOAD_A: begin
                w_ready = 1'b1;
                if (cfg.CFG_ABORT) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (cfg.CFG_VALID) begin
                    w_wr_a = 1'b1;
                    if (r_cnt == LAST) begin
                        w_state_nxt = LOAD_B;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                w_ready = 1'b1;
                if (cfg.CFG_ABORT) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (cfg.CFG_VALID) begin
                    w_wr_b = 1'b1;
                    if (r_cnt == LAST) begin
                        w_state_nxt = COMMIT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            COMMIT: begin
                w_done      = 1'b1;
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // staging shift-in; contents only matter once a full load reaches COMMIT
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_stg_a <= '0;
            r_stg_b <= '0;
        end else begin
            if (w_wr_a) r_stg_a[w_idx] <= cfg.CFG_DIN;
            if (w_wr_b) r_stg_b[w_idx] <= cfg.CFG_DIN;
        end
    end

    // active tables swap together so the mux never sees A and B from different loads
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_act_a <= INIT_A;
            r_act_b <= INIT_B;
        end else if (w_commit) begin
            r_act_a <= r_stg_a;
            r_act_b <= r_stg_b;
        end
    end

    // registered LUT evaluation, every cycle regardless of load state
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_alut <= 1'b0;
            r_blut <= 1'b0;
        end else begin
            r_alut <= r_act_a[LUT_IN];
            r_blut <= r_act_b[LUT_IN];
        end
    end

    assign ALUT          = r_alut;
    assign BLUT          = r_blut;
    assign cfg.CFG_READY = w_ready;
    assign cfg.CFG_DONE  = w_done;

`ifdef PFU_LUT_READBACK_EN
    // readback of the outgoing table at the index currently being replaced
    always_comb begin
        cfg.CFG_DOUT = 1'b0;
        case (r_state)
            LOAD_A:  cfg.CFG_DOUT = r_act_a[w_idx];
            LOAD_B:  cfg.CFG_DOUT = r_act_b[w_idx];
            default: cfg.CFG_DOUT = 1'b0;
        endcase
    end
`endif
endmodule
